nvme_mmio_bridge: RTL
=====================

NVME_MMIO_BRIDGE -- requirements
Module: nvme_mmio_bridge

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 128, the AXIS data width; only 128 is supported.
REQ-002 SHALL have parameter KEEP_WIDTH, default C_DATA_WIDTH/32, the tkeep width.
REQ-003 SHALL have parameter AXI4_RQ_TUSER_WIDTH, default 62, the RQ tuser width.
REQ-004 SHALL have parameter AXI4_RC_TUSER_WIDTH, default 75, the RC tuser width.
REQ-005 SHALL have parameter REQUESTER_ID, default 16'h10EE, the requester ID placed in every request descriptor.
REQ-006 SHALL have parameter BAR_BASE, default 64'h0, the controller BAR0 base address.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 50000, the read completion timeout in cycles.
REQ-008 SHALL have port user_clk, input, 1 bit: the single clock.
REQ-009 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have the MMIO request ports: req_valid in 1; req_ready out 1; req_write in 1; req_addr in 12 (byte offset; bits [1:0] ignored); req_wdata in 32; req_be in 4.
REQ-011 SHALL have the response ports: rsp_valid out 1; rsp_rdata out 32; rsp_err out 1; rsp_timeout out 1.
REQ-012 SHALL have the RQ master ports usr_s_axis_rq_tdata/tkeep/tuser/tlast/tvalid (out, C_DATA_WIDTH/KEEP_WIDTH/AXI4_RQ_TUSER_WIDTH/1/1) and usr_s_axis_rq_tready (in, 1).
REQ-013 SHALL have the RC slave ports usr_m_axis_rc_tdata/tkeep/tlast/tvalid/tuser as inputs; there is no tready, so the block accepts every beat.

Function
REQ-014 SHALL use the FSM states IDLE, WR_DESC, WR_DATA, RD_DESC, RD_WAIT and RESP.
REQ-015 SHALL assert req_ready only in IDLE; on req_valid&&req_ready it SHALL latch the request and go to WR_DESC if req_write, else to RD_DESC.
REQ-016 SHALL drive the descriptor beat as:
- address [63:2] = (BAR_BASE+req_addr)>>2; [1:0]=0
- [74:64] dword count = 1; [78:75] = 0001 for write, 0000 for read
- [95:80] = REQUESTER_ID; [103:96] = tag
- all other bits = 0
REQ-017 SHALL drive tuser[3:0] = latched be and tuser[7:4] = 0.
REQ-018 SHALL, for a write, send the descriptor beat with tkeep=4'hF and tlast=0, then a data beat with tdata[31:0]=wdata, tkeep=4'h1 and tlast=1.
REQ-019 SHALL, for a read, send a single beat with tkeep=4'hF and tlast=1.
REQ-020 SHALL hold tvalid and all RQ outputs stable until tready; a state advances only on tvalid&&tready.
REQ-021 SHALL treat writes as posted: after the data beat handshakes, go to RESP with rsp_err=0.
REQ-022 SHALL, in RD_WAIT, accept an RC beat with tvalid and tdata[71:64]==tag as the completion:
- rsp_rdata = tdata[127:96]
- rsp_err = (tdata[45:43]!=0) || tdata[46]
- then go to RESP
REQ-023 SHALL ignore RC beats whose tag does not match, or that arrive outside RD_WAIT.
REQ-024 SHALL pulse rsp_valid for exactly one cycle in RESP, then return to IDLE.
REQ-025 SHALL increment the 8-bit tag after each read descriptor handshake, wrapping 255->0.
REQ-026 SHALL give a read a minimum latency from request acceptance to rsp_valid of completion arrival cycle + 1.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force: state=IDLE, tag=0, timeout counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, RQ tvalid=0, tlast=0, tdata/tkeep/tuser=0.
REQ-028 SHALL resume in IDLE after reset deasserts mid-transaction, with no response for the aborted request; a late completion is dropped by tag mismatch only if the tag had advanced.

Configuration
REQ-029 SHALL, with macro NVME_MMIO_TIMEOUT_EN defined, count cycles in RD_WAIT; at TIMEOUT_CYCLES-1 it SHALL go to RESP with rsp_timeout=1, rsp_err=1 and rsp_rdata=32'hFFFFFFFF.
REQ-030 SHALL, when a matching completion and timeout expiry occur in the same cycle, let the completion win.
REQ-031 SHALL, without NVME_MMIO_TIMEOUT_EN, omit the counter, tie rsp_timeout to 0 and wait in RD_WAIT indefinitely.

Structure
REQ-032 SHALL place the state enum, request type codes (MEMRD=4'b0000, MEMWR=4'b0001) and RQ/RC descriptor bit-offset constants in shared package nvme_mmio_pkg.
REQ-033 SHALL implement completion field extraction and tag compare in sub-module nvme_mmio_rc_parse; the FSM stays in the top module.

Verification
REQ-034 SHALL cover: write addr 12'h014, wdata 32'h00460001, be F, tready=1 -> two beats, beat0 [78:75]=0001, beat1 tdata[31:0]=32'h00460001, tkeep=1, tlast=1; rsp_valid with rsp_err=0.
REQ-035 SHALL cover: read 12'h01C, completion tag=0, status 0, tdata[127:96]=32'h00000001 -> rsp_rdata=32'h00000001, rsp_err=0; next read uses tag 1.
REQ-036 SHALL cover: read with tready low for 5 cycles -> tvalid held and descriptor unchanged across all 5 cycles; single handshake.
REQ-037 SHALL cover: completion with wrong tag 8'h7F, then correct tag -> first ignored, response from second; completion status 3'b001 -> rsp_err=1.
REQ-038 SHALL cover: with NVME_MMIO_TIMEOUT_EN and TIMEOUT_CYCLES=16, no completion -> rsp_valid 16 cycles after descriptor accept, rsp_timeout=1, rsp_rdata=32'hFFFFFFFF.
REQ-039 SHALL cover: 256 reads -> tag wraps 255->0; reset_n pulsed in RD_WAIT -> IDLE, all outputs 0, no rsp_valid.

Source files
------------

// File: rtl/nvme_mmio_pkg.sv
// Shared FSM state type, request type codes and RQ/RC descriptor layout for the
// NVMe MMIO bridge.
package nvme_mmio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_DESC,
    WR_DATA,
    RD_DESC,
    RD_WAIT,
    RESP
  } state_e;

  localparam logic [3:0] MEMRD = 4'b0000;
  localparam logic [3:0] MEMWR = 4'b0001;

  localparam int unsigned RQ_ADDR_LSB  = 2;
  localparam int unsigned RQ_DWCNT_LSB = 64;
  localparam int unsigned RQ_TYPE_LSB  = 75;
  localparam int unsigned RQ_REQID_LSB = 80;
  localparam int unsigned RQ_TAG_LSB   = 96;

  localparam int unsigned RC_STATUS_LSB = 43;
  localparam int unsigned RC_POISON_BIT = 46;
  localparam int unsigned RC_TAG_LSB    = 64;
  localparam int unsigned RC_DATA_LSB   = 96;

  // Single-dword memory request descriptor; the byte offset within the dword is dropped.
  function automatic logic [127:0] rq_desc(input logic [63:0] addr, input logic [3:0] req_type,
                                           input logic [15:0] req_id, input logic [7:0] tag);
    logic [127:0] d;
    d = '0;
    d[63:RQ_ADDR_LSB]       = addr[63:RQ_ADDR_LSB];
    d[RQ_DWCNT_LSB +: 11]   = 11'd1;
    d[RQ_TYPE_LSB +: 4]     = req_type;
    d[RQ_REQID_LSB +: 16]   = req_id;
    d[RQ_TAG_LSB +: 8]      = tag;
    return d;
  endfunction

endpackage

// File: rtl/nvme_mmio_rc_parse.sv
// Completion beat decode: tag match against the outstanding read, read data and
// error status extraction.
module nvme_mmio_rc_parse
  import nvme_mmio_pkg::*;
#(
  parameter int C_DATA_WIDTH = 128,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32,
  parameter int TUSER_WIDTH  = 75
) (
  input  logic [C_DATA_WIDTH-1:0] tdata,
  input  logic [KEEP_WIDTH-1:0]   tkeep,
  input  logic                    tlast,
  input  logic                    tvalid,
  input  logic [TUSER_WIDTH-1:0]  tuser,
  input  logic                    armed,
  input  logic [7:0]              exp_tag,
  output logic                    hit,
  output logic [31:0]             rdata,
  output logic                    err
);

  assign hit   = armed && tvalid && (tdata[RC_TAG_LSB +: 8] == exp_tag);
  assign rdata = tdata[RC_DATA_LSB +: 32];
  assign err   = (tdata[RC_STATUS_LSB +: 3] != 3'b000) || tdata[RC_POISON_BIT];

  // Only a few completion fields matter for single-dword MMIO reads.
  logic unused_rc;
  assign unused_rc = ^{tdata, tkeep, tlast, tuser};

endmodule

// File: rtl/nvme_mmio_bridge.sv
// Single-outstanding 32-bit MMIO bridge onto the PCIe RQ/RC AXI-Stream interfaces.
// Optional read completion timeout enabled by defining NVME_MMIO_TIMEOUT_EN.
module nvme_mmio_bridge
  import nvme_mmio_pkg::*;
#(
  parameter int          C_DATA_WIDTH        = 128,
  parameter int          KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int          AXI4_RQ_TUSER_WIDTH = 62,
  parameter int          AXI4_RC_TUSER_WIDTH = 75,
  parameter logic [15:0] REQUESTER_ID        = 16'h10EE,
  parameter logic [63:0] BAR_BASE            = 64'h0,
  parameter int          TIMEOUT_CYCLES      = 50000
) (
  input  logic                           user_clk,
  input  logic                           reset_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [11:0]                    req_addr,
  input  logic [31:0]                    req_wdata,
  input  logic [3:0]                     req_be,
  output logic                           rsp_valid,
  output logic [31:0]                    rsp_rdata,
  output logic                           rsp_err,
  output logic                           rsp_timeout,
  output logic [C_DATA_WIDTH-1:0]        usr_s_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]          usr_s_axis_rq_tkeep,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0] usr_s_axis_rq_tuser,
  output logic                           usr_s_axis_rq_tlast,
  output logic                           usr_s_axis_rq_tvalid,
  input  logic                           usr_s_axis_rq_tready,
  input  logic [C_DATA_WIDTH-1:0]        usr_m_axis_rc_tdata,
  input  logic [KEEP_WIDTH-1:0]          usr_m_axis_rc_tkeep,
  input  logic                           usr_m_axis_rc_tlast,
  input  logic                           usr_m_axis_rc_tvalid,
  input  logic [AXI4_RC_TUSER_WIDTH-1:0] usr_m_axis_rc_tuser
);

  state_e      state_q, state_d;
  logic        ready_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [7:0]  tag_q, tag_d;
  logic [7:0]  rd_tag_q, rd_tag_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;

  logic         accept;
  logic         rc_hit;
  logic [31:0]  rc_rdata;
  logic         rc_err;
  logic         tmo_expire;
  logic [127:0] desc_wr, desc_rd;

  assign accept      = req_valid && ready_q;
  assign req_ready   = ready_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;

  assign desc_wr = rq_desc(BAR_BASE + {52'h0, addr_q}, MEMWR, REQUESTER_ID, tag_q);
  assign desc_rd = rq_desc(BAR_BASE + {52'h0, addr_q}, MEMRD, REQUESTER_ID, tag_q);

  nvme_mmio_rc_parse #(
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .KEEP_WIDTH   (KEEP_WIDTH),
    .TUSER_WIDTH  (AXI4_RC_TUSER_WIDTH)
  ) u_rc_parse (
    .tdata   (usr_m_axis_rc_tdata),
    .tkeep   (usr_m_axis_rc_tkeep),
    .tlast   (usr_m_axis_rc_tlast),
    .tvalid  (usr_m_axis_rc_tvalid),
    .tuser   (usr_m_axis_rc_tuser),
    .armed   (state_q == RD_WAIT),
    .exp_tag (rd_tag_q),
    .hit     (rc_hit),
    .rdata   (rc_rdata),
    .err     (rc_err)
  );

`ifdef NVME_MMIO_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
    end else if (state_q == RD_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign tmo_expire = (state_q == RD_WAIT) && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d              = state_q;
    tag_d                = tag_q;
    rd_tag_d             = rd_tag_q;
    rdata_d              = rdata_q;
    err_d                = err_q;
    tmo_d                = tmo_q;
    usr_s_axis_rq_tvalid = 1'b0;
    usr_s_axis_rq_tlast  = 1'b0;
    usr_s_axis_rq_tdata  = '0;
    usr_s_axis_rq_tkeep  = '0;
    usr_s_axis_rq_tuser  = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = req_write ? WR_DESC : RD_DESC;
      end
      WR_DESC: begin
        usr_s_axis_rq_tvalid     = 1'b1;
        usr_s_axis_rq_tdata      = C_DATA_WIDTH'(desc_wr);
        usr_s_axis_rq_tkeep      = KEEP_WIDTH'(4'hF);
        usr_s_axis_rq_tuser[3:0] = be_q;
        if (usr_s_axis_rq_tready) state_d = WR_DATA;
      end
      WR_DATA: begin
        usr_s_axis_rq_tvalid     = 1'b1;
        usr_s_axis_rq_tlast      = 1'b1;
        usr_s_axis_rq_tdata      = C_DATA_WIDTH'(wdata_q);
        usr_s_axis_rq_tkeep      = KEEP_WIDTH'(4'h1);
        usr_s_axis_rq_tuser[3:0] = be_q;
        if (usr_s_axis_rq_tready) begin
          // Posted write: respond as soon as the data beat is taken.
          rdata_d = '0;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = RESP;
        end
      end
      RD_DESC: begin
        usr_s_axis_rq_tvalid     = 1'b1;
        usr_s_axis_rq_tlast      = 1'b1;
        usr_s_axis_rq_tdata      = C_DATA_WIDTH'(desc_rd);
        usr_s_axis_rq_tkeep      = KEEP_WIDTH'(4'hF);
        usr_s_axis_rq_tuser[3:0] = be_q;
        if (usr_s_axis_rq_tready) begin
          rd_tag_d = tag_q;
          tag_d    = tag_q + 8'd1;
          state_d  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // A completion arriving on the expiry cycle takes priority over the timeout.
        if (rc_hit) begin
          rdata_d = rc_rdata;
          err_d   = rc_err;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_expire) begin
          rdata_d = 32'hFFFF_FFFF;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      tag_q    <= '0;
      rd_tag_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d == IDLE);
      tag_q    <= tag_d;
      rd_tag_q <= rd_tag_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

endmodule
